// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the iteration counter width.
package mult_div_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    // Must hold the value DATA_WIDTH itself, hence one bit above log2.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one bit per cycle on magnitudes,
// sign correction in a final cycle, fixed DATA_WIDTH+1 cycle latency.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo writes allowed
// RUN   | DATA_WIDTH shift-add / restoring shift-subtract iterations
// FIX   | sign correction, hi/lo write, done pulse on the way out
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  flush,
    input  logic                  mthi,
    input  logic                  mtlo,
    input  logic [DATA_WIDTH-1:0] mt_data,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  busy,
    output logic                  done,
    output logic                  div_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(W);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  qr_q, qr_d;
    logic [W-1:0]  opnd_q, opnd_d;
    logic          is_div_q, is_div_d;
    logic          neg_q, neg_d;
    logic          neg_rem_q, neg_rem_d;
    logic          dz_q, dz_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic          done_q, done_d;
    logic          div_zero_q, div_zero_d;

    op_e           op_sel;
    logic          op_signed;
    logic          op_div;
    logic [W-1:0]  a_abs;
    logic [W-1:0]  b_abs;
    logic [W:0]    mul_sum;
    logic [W:0]    div_shift;
    logic          div_ge;
    logic [W-1:0]  div_sub;

    assign op_sel    = op_e'(op);
    assign op_signed = (op_sel == OP_MULT) || (op_sel == OP_DIV);
    assign op_div    = (op_sel == OP_DIV) || (op_sel == OP_DIVU);
    assign a_abs     = (op_signed && A[W-1]) ? -A : A;
    assign b_abs     = (op_signed && B[W-1]) ? -B : B;

    // acc:qr forms the shifting product (multiply) or remainder:dividend/quotient (divide)
    assign mul_sum   = {1'b0, acc_q} + (qr_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {acc_q, qr_q[W-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_sub   = div_shift[W-1:0] - opnd_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        qr_d       = qr_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (mthi) hi_d = mt_data;
                if (mtlo) lo_d = mt_data;
                if (start && !flush) begin
                    state_d   = S_RUN;
                    cnt_d     = CNT_LOAD;
                    acc_d     = '0;
                    is_div_d  = op_div;
                    qr_d      = op_div ? a_abs : b_abs;
                    opnd_d    = op_div ? b_abs : a_abs;
                    neg_d     = op_signed && (A[W-1] ^ B[W-1]);
                    neg_rem_d = op_signed && A[W-1];
                    dz_d      = op_div && (B == '0);
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_d = S_FIX;
                    if (is_div_q) begin
                        acc_d = div_ge ? div_sub : div_shift[W-1:0];
                        qr_d  = {qr_q[W-2:0], div_ge};
                    end else begin
                        acc_d = mul_sum[W:1];
                        qr_d  = {mul_sum[0], qr_q[W-1:1]};
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done_d     = 1'b1;
                    div_zero_d = dz_q;
                    if (is_div_q) begin
                        // Divide by zero leaves |A| in acc, so the remainder path restores A.
                        hi_d = neg_rem_q ? -acc_q : acc_q;
                        lo_d = dz_q ? '1 : (neg_q ? -qr_q : qr_q);
                    end else begin
                        {hi_d, lo_d} = neg_q ? -{acc_q, qr_q} : {acc_q, qr_q};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            qr_q       <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            qr_q       <= qr_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: the driver pushes reference results,
// a negedge monitor pops and compares them whenever done pulses.
module tb_mult_div_unit;
    import mult_div_pkg::*;

    localparam int LAT = 33;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, start, flush, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] A, B, mt_data, hi, lo;
    logic        busy, done, div_zero;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .flush(flush), .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain wide arithmetic; SV signed / and % truncate toward zero.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.dz = 1'b0;
        e.done_cyc = 0;
        p = '0;
        if (o[1] && b == 32'd0) begin
            p = {a, 32'hFFFF_FFFF};
            e.dz = 1'b1;
        end else begin
            case (o)
                2'b00: p = sa * sb;
                2'b01: p = {32'd0, a} * {32'd0, b};
                2'b10: begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
                default: p = {a % b, a / b};
            endcase
        end
        e.hi = p[63:32];
        e.lo = p[31:0];
        return e;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 hi=0x%0h lo=0x%0h, required no done", hi, lo);
            end else begin
                mon_e = sb_q.pop_front();
                chk("hi", hi, mon_e.hi);
                chk("lo", lo, mon_e.lo);
                chk("div_zero", div_zero, mon_e.dz);
                chk("latency_cycle", cyc, mon_e.done_cyc);
                chk("busy_at_done", busy, 0);
            end
        end else begin
            if (sb_q.size() > 0 && cyc > sb_q[0].done_cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_timeout: got no done by cycle %0d, required done at %0d", cyc, sb_q[0].done_cyc);
                void'(sb_q.pop_front());
            end
            if (div_zero) begin
                n_checks++;
                n_fail++;
                $display("FAIL stray_div_zero: got div_zero=1 without done, required 0");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: got busy=1 after %0d cycles, required 0", n);
        end
    endtask

    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int acc);
        wait_idle();
        start = 1'b1;
        op = o;
        A = a;
        B = b;
        tick();
        start = 1'b0;
        acc = cyc;
        chk("busy_after_accept", busy, 1);
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int   acc;
        exp_t e;
        start_op(o, a, b, acc);
        e = model(o, a, b);
        e.done_cyc = acc + LAT;
        sb_q.push_back(e);
    endtask

    task automatic issue_k(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
        int   acc;
        exp_t e;
        start_op(o, a, b, acc);
        e.hi = ehi;
        e.lo = elo;
        e.dz = edz;
        e.done_cyc = acc + LAT;
        sb_q.push_back(e);
    endtask

    initial begin
        int          acc;
        int          n;
        logic [31:0] ph, pl;
        exp_t        e;

        reset = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        mthi = 1'b0;
        mtlo = 1'b0;
        op = 2'b00;
        A = '0;
        B = '0;
        mt_data = '0;
        repeat (3) tick();
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        reset = 1'b1;
        tick();

        issue_k(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        issue_k(OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        issue_k(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        issue_k(OP_DIVU, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1);
        issue_k(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        issue_k(OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

        // start while busy is ignored; mtlo while busy leaves lo alone
        wait_idle();
        tick();
        pl = lo;
        issue(OP_MULTU, 32'd1000, 32'd3);
        repeat (4) tick();
        start = 1'b1;
        op = OP_DIVU;
        A = 32'd99;
        B = 32'd9;
        mtlo = 1'b1;
        mt_data = 32'hDEAD_BEEF;
        tick();
        start = 1'b0;
        mtlo = 1'b0;
        chk("lo_mtlo_during_run", lo, pl);

        // flush at cycle 10 of a MULTU
        wait_idle();
        tick();
        ph = hi;
        pl = lo;
        start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc);
        repeat (3) tick();
        start = 1'b1;
        op = OP_MULT;
        A = 32'd3;
        B = 32'd4;
        tick();
        start = 1'b0;
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("busy_after_flush", busy, 0);
        chk("hi_after_flush", hi, ph);
        chk("lo_after_flush", lo, pl);
        repeat (40) tick();
        chk("hi_flush_settled", hi, ph);
        chk("lo_flush_settled", lo, pl);

        // flush while in the fix-up cycle
        start_op(OP_DIVU, 32'd100, 32'd7, acc);
        repeat (32) tick();
        chk("busy_in_fix", busy, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("busy_after_fix_flush", busy, 0);
        chk("hi_after_fix_flush", hi, ph);
        chk("lo_after_fix_flush", lo, pl);
        repeat (3) tick();

        // flush beats start in IDLE
        flush = 1'b1;
        start = 1'b1;
        op = OP_MULTU;
        A = 32'd5;
        B = 32'd5;
        tick();
        flush = 1'b0;
        start = 1'b0;
        chk("busy_flush_start_idle", busy, 0);
        repeat (40) tick();
        chk("lo_flush_start_idle", lo, pl);

        mthi = 1'b1;
        mt_data = 32'h0000_1234;
        tick();
        mthi = 1'b0;
        chk("mthi_idle", hi, 32'h0000_1234);
        mtlo = 1'b1;
        mt_data = 32'h0000_5678;
        tick();
        mtlo = 1'b0;
        chk("mtlo_idle", lo, 32'h0000_5678);

        // mtlo with an accepted start writes, then the result overwrites
        mtlo = 1'b1;
        mt_data = 32'h0000_CAFE;
        start = 1'b1;
        op = OP_MULTU;
        A = 32'd9;
        B = 32'd9;
        tick();
        start = 1'b0;
        mtlo = 1'b0;
        chk("mtlo_with_start", lo, 32'h0000_CAFE);
        e = model(OP_MULTU, 32'd9, 32'd9);
        e.done_cyc = cyc + LAT;
        sb_q.push_back(e);

        // reset in the middle of a DIV
        start_op(OP_DIV, 32'h1234_5678, 32'd3, acc);
        repeat (5) tick();
        reset = 1'b0;
        #1;
        chk("rst_mid_hi", hi, 0);
        chk("rst_mid_lo", lo, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_div_zero", div_zero, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        issue_k(OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);

        for (int i = 0; i < 30; i++) begin
            issue(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand());
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 2)) tick();
        end

        n = 0;
        while (sb_q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d results outstanding, required 0", sb_q.size());
        end
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
